hazard_ctrl: RTL

Parametrised pipeline hazard controller for the 5-stage MIPS core, replacing the single-cycle load-use detector. It sits beside the ID stage and owns four things:
- load-use stalls with a configurable load latency;
- branch flushes;
- whole-pipeline freeze while the data cache is not ready;
- EX-stage operand forwarding selects.

A registered state machine tracks multi-cycle stalls, and a counter records stall cycles for performance analysis.

---
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and hazard_ctrl.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
// REG_AW and CNT_W must match the values given to hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    // Pipeline state observed by the hazard controller
    logic [REG_AW-1:0] ifIdRs;
    logic [REG_AW-1:0] ifIdRt;
    logic [REG_AW-1:0] idExRs;
    logic [REG_AW-1:0] idExRt;
    logic [REG_AW-1:0] idExRd;
    logic [REG_AW-1:0] exMemRd;
    logic [REG_AW-1:0] memWbRd;
    logic              idExMR;
    logic              idExRW;
    logic              exMemRW;
    logic              memWbRW;
    logic              branchTaken;
    logic              memReq;
    logic              memReady;

    // Pipeline controls produced by the hazard controller
    logic              pcWrite;
    logic              ifIdW;
    logic              controlMux;
    logic              ifIdFlush;
    logic              pipeFreeze;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic [CNT_W-1:0]  stallCycles;

    modport master (
        output ifIdRs, ifIdRt, idExRs, idExRt, idExRd, exMemRd, memWbRd,
        output idExMR, idExRW, exMemRW, memWbRW, branchTaken, memReq, memReady,
        input  pcWrite, ifIdW, controlMux, ifIdFlush, pipeFreeze, fwdA, fwdB,
        input  stallCycles
    );

    modport slave (
        input  ifIdRs, ifIdRt, idExRs, idExRt, idExRd, exMemRd, memWbRd,
        input  idExMR, idExRW, exMemRW, memWbRW, branchTaken, memReq, memReady,
        output pcWrite, ifIdW, controlMux, ifIdFlush, pipeFreeze, fwdA, fwdB,
        output stallCycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use stalls with
// configurable latency, branch flushes, data-cache freeze, EX operand
// forwarding selects and a stall-cycle performance counter.
// Build option: define HAZARD_FWD_EN to enable the forwarding unit; when it is
// undefined forwarding selects are tied to 00 and RUN-state RAW hazards stall.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LU_INIT = 4'(LOAD_LAT - 1);

    state_t           r_state;
    state_t           r_retState;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stallCycles;

    state_t           w_effState;
    state_t           w_nState;
    state_t           w_nRet;
    logic [3:0]       w_nCnt;
    logic             w_luHaz;
    logic             w_memWait;
    logic             w_rawHaz;
    logic             w_pcWrite;
    logic             w_ifIdW;
    logic             w_controlMux;
    logic             w_ifIdFlush;
    logic             w_pipeFreeze;
    logic [1:0]       w_fwdRawA;
    logic [1:0]       w_fwdRawB;
    logic             w_unused;

    assign w_luHaz = bus.idExMR && (bus.idExRt != '0) &&
                     ((bus.idExRt == bus.ifIdRs) || (bus.idExRt == bus.ifIdRt));

    assign w_memWait = bus.memReq && !bus.memReady;

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              exRW,
        input logic [REG_AW-1:0] exRd,
        input logic              wbRW,
        input logic [REG_AW-1:0] wbRd
    );
        if (src == '0)                 return 2'b00;
        if (exRW && (exRd == src))     return 2'b10;
        if (wbRW && (wbRd == src))     return 2'b01;
        return 2'b00;
    endfunction

    assign w_fwdRawA = fwd_sel(bus.idExRs, bus.exMemRW, bus.exMemRd, bus.memWbRW, bus.memWbRd);
    assign w_fwdRawB = fwd_sel(bus.idExRt, bus.exMemRW, bus.exMemRd, bus.memWbRW, bus.memWbRd);
    assign w_rawHaz  = 1'b0;
    assign w_unused  = ^{bus.idExRW, bus.idExRd};
`else
    function automatic logic raw_match(
        input logic [REG_AW-1:0] src,
        input logic              exRW,
        input logic [REG_AW-1:0] exRd,
        input logic              memRW,
        input logic [REG_AW-1:0] memRd
    );
        return (src != '0) && ((exRW && (exRd == src)) || (memRW && (memRd == src)));
    endfunction

    assign w_fwdRawA = 2'b00;
    assign w_fwdRawB = 2'b00;
    assign w_rawHaz  = raw_match(bus.ifIdRs, bus.idExRW, bus.idExRd, bus.exMemRW, bus.exMemRd) ||
                       raw_match(bus.ifIdRt, bus.idExRW, bus.idExRd, bus.exMemRW, bus.exMemRd);
    assign w_unused  = ^{bus.idExRs, bus.memWbRW, bus.memWbRd};
`endif

    // MEM_WAIT behaves as the interrupted state once the cache is ready, so the
    // held LU_STALL count resumes in the very cycle memReady arrives.
    assign w_effState = (r_state == MEM_WAIT) ? r_retState : r_state;

    // Control decode and next-state selection, highest priority first
    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifIdW      = 1'b1;
        w_controlMux = 1'b1;
        w_ifIdFlush  = 1'b0;
        w_pipeFreeze = 1'b0;
        w_nState     = w_effState;
        w_nCnt       = r_cnt;
        w_nRet       = r_retState;
        if (reset) begin
            w_nState = RUN;
        end else if (w_memWait) begin
            w_pcWrite    = 1'b0;
            w_ifIdW      = 1'b0;
            w_pipeFreeze = 1'b1;
            w_nState     = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_nRet = r_state;
            end
        end else begin
            unique case (w_effState)
                RUN: begin
                    if (bus.branchTaken) begin
                        w_ifIdFlush  = 1'b1;
                        w_controlMux = 1'b0;
                    end else if (w_luHaz) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdW      = 1'b0;
                        w_controlMux = 1'b0;
                        if (LOAD_LAT > 1) begin
                            w_nState = LU_STALL;
                            w_nCnt   = LU_INIT;
                        end
                    end else if (w_rawHaz) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdW      = 1'b0;
                        w_controlMux = 1'b0;
                    end
                end
                LU_STALL: begin
                    w_pcWrite    = 1'b0;
                    w_ifIdW      = 1'b0;
                    w_controlMux = 1'b0;
                    w_nCnt       = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_nState = RUN;
                    end
                end
                default: begin
                    w_nState = RUN;
                end
            endcase
        end
    end

    // State, stall countdown, return state and performance counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_retState    <= RUN;
            r_cnt         <= '0;
            r_stallCycles <= '0;
        end else begin
            r_state    <= w_nState;
            r_retState <= w_nRet;
            r_cnt      <= w_nCnt;
            if (!w_pcWrite) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
        end
    end

    assign bus.pcWrite     = w_pcWrite;
    assign bus.ifIdW       = w_ifIdW;
    assign bus.controlMux  = w_controlMux;
    assign bus.ifIdFlush   = w_ifIdFlush;
    assign bus.pipeFreeze  = w_pipeFreeze;
    assign bus.fwdA        = reset ? 2'b00 : w_fwdRawA;
    assign bus.fwdB        = reset ? 2'b00 : w_fwdRawB;
    assign bus.stallCycles = r_stallCycles;

endmodule
